// File: rtl/sim_run_controller_if.sv
// Command and status bundle between a bench harness and the run sequencer.
// The master side issues start/abort and reports core halts; the slave side sequences the run.
interface sim_run_controller_if #(
    parameter int N_CORES = 2,
    parameter int CNT_W   = 32
);
    logic                       start;
    logic                       abort;
    logic [N_CORES-1:0]         core_halt;
    logic [N_CORES-1:0]         core_rst;
    logic                       running;
    logic                       done;
    logic                       timeout;
    logic                       aborted;
    logic [N_CORES-1:0]         halted_mask;
    logic [N_CORES*CNT_W-1:0]   cycles_bus;
    logic [CNT_W-1:0]           total_cycles;

    modport master (
        output start, abort, core_halt,
        input  core_rst, running, done, timeout, aborted,
               halted_mask, cycles_bus, total_cycles
    );

    modport slave (
        input  start, abort, core_halt,
        output core_rst, running, done, timeout, aborted,
               halted_mask, cycles_bus, total_cycles
    );
endinterface

// File: rtl/sim_run_controller.sv
// Run sequencer for cores under test: holds core reset, runs the cores, and
// records per-core cycle counts until all halt, the budget expires, or an abort.
module sim_run_controller #(
    parameter int N_CORES      = 2,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000,
    parameter int CNT_W        = 32
) (
    input logic                  InputClk,
    input logic                  rst,
    sim_run_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE
    } RunState;

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

    RunState               state;
    logic [HOLD_W-1:0]     holdCnt;
    logic [N_CORES-1:0]    coreRstReg;
    logic                  runningReg;
    logic                  doneReg;
    logic                  timeoutReg;
    logic                  abortedReg;
    logic [N_CORES-1:0]    haltedMask;
    logic [CNT_W-1:0]      cycleCnt [N_CORES];
    logic [CNT_W-1:0]      totalCnt;

    logic [N_CORES-1:0]    nextMask;
    logic                  allHalted;
    logic                  runEnds;
    logic [N_CORES*CNT_W-1:0] cyclesFlat;

    // Halts seen this cycle already count toward "all halted".
    always_comb begin
        nextMask  = haltedMask | bus.core_halt;
        allHalted = &nextMask;
        runEnds   = allHalted || bus.abort || (totalCnt == BUDGET_LAST);
    end

    always_comb begin
        cyclesFlat = '0;
        for (int i = 0; i < N_CORES; i++) begin
            cyclesFlat[i*CNT_W +: CNT_W] = cycleCnt[i];
        end
    end

    always_ff @(posedge InputClk) begin
        if (rst) begin
            state      <= IDLE;
            holdCnt    <= '0;
            coreRstReg <= '1;
            runningReg <= 1'b0;
            doneReg    <= 1'b0;
            timeoutReg <= 1'b0;
            abortedReg <= 1'b0;
            haltedMask <= '0;
            totalCnt   <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                cycleCnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RESET_HOLD;
                        holdCnt    <= '0;
                        doneReg    <= 1'b0;
                        timeoutReg <= 1'b0;
                        abortedReg <= 1'b0;
                        haltedMask <= '0;
                        totalCnt   <= '0;
                        for (int i = 0; i < N_CORES; i++) begin
                            cycleCnt[i] <= '0;
                        end
                    end
                end

                RESET_HOLD: begin
                    if (holdCnt == HOLD_LAST) begin
                        state      <= RUN;
                        coreRstReg <= '0;
                        runningReg <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end

                RUN: begin
                    totalCnt   <= totalCnt + 1'b1;
                    haltedMask <= nextMask;
                    // A core's count includes its halt cycle and then freezes.
                    for (int i = 0; i < N_CORES; i++) begin
                        if (!haltedMask[i]) begin
                            cycleCnt[i] <= cycleCnt[i] + 1'b1;
                        end
                    end
                    if (runEnds) begin
                        state      <= DONE;
                        coreRstReg <= '1;
                        runningReg <= 1'b0;
                        doneReg    <= 1'b1;
                        abortedReg <= !allHalted && bus.abort;
                        timeoutReg <= !allHalted && !bus.abort;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_rst     = coreRstReg;
    assign bus.running      = runningReg;
    assign bus.done         = doneReg;
    assign bus.timeout      = timeoutReg;
    assign bus.aborted      = abortedReg;
    assign bus.halted_mask  = haltedMask;
    assign bus.cycles_bus   = cyclesFlat;
    assign bus.total_cycles = totalCnt;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: a run-level model (halt cycle per core,
// elapsed RUN cycles) is compared against the DUT every cycle, plus literal checks.
module tb_sim_run_controller;

    localparam int N_CORES      = 2;
    localparam int RESET_CYCLES = 4;
    localparam int MAX_CYCLES   = 20;
    localparam int CNT_W        = 32;

    logic InputClk = 1'b0;
    logic rst;

    sim_run_controller_if #(.N_CORES(N_CORES), .CNT_W(CNT_W)) runIf ();

    sim_run_controller #(
        .N_CORES      (N_CORES),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .InputClk (InputClk),
        .rst      (rst),
        .bus      (runIf)
    );

    always #5 InputClk = ~InputClk;

    int checks = 0;
    int fails  = 0;

    // Model: which phase of a run we are in, RUN cycles elapsed, and the RUN
    // cycle on which each core first halted (0 = not yet halted).
    bit mValid = 1'b0;
    bit mIdle  = 1'b1;
    bit mDone  = 1'b0;
    bit mTimeout, mAborted;
    int holdLeft = 0;
    int mTotal   = 0;
    int haltAt [N_CORES];

    function automatic bit mRunning();
        return mValid && !mIdle && !mDone && (holdLeft == 0);
    endfunction

    function automatic logic [N_CORES-1:0] mMask();
        logic [N_CORES-1:0] m;
        for (int i = 0; i < N_CORES; i++) m[i] = (haltAt[i] != 0);
        return m;
    endfunction

    function automatic logic [N_CORES*CNT_W-1:0] mCycles();
        logic [N_CORES*CNT_W-1:0] v;
        for (int i = 0; i < N_CORES; i++)
            v[i*CNT_W +: CNT_W] = CNT_W'((haltAt[i] != 0) ? haltAt[i] : mTotal);
        return v;
    endfunction

    task automatic clearRun();
        mTotal   = 0;
        mTimeout = 1'b0;
        mAborted = 1'b0;
        for (int i = 0; i < N_CORES; i++) haltAt[i] = 0;
    endtask

    task automatic updateModel(input logic r, input logic s, input logic a,
                               input logic [N_CORES-1:0] h);
        bit everyoneHalted;
        if (r) begin
            mValid = 1'b1; mIdle = 1'b1; mDone = 1'b0; holdLeft = 0;
            clearRun();
        end else if (!mValid) begin
            mIdle = 1'b1;
        end else if ((mIdle || mDone) && s) begin
            mIdle = 1'b0; mDone = 1'b0; holdLeft = RESET_CYCLES;
            clearRun();
        end else if (holdLeft > 0) begin
            holdLeft--;
        end else if (!mIdle && !mDone) begin
            mTotal++;
            everyoneHalted = 1'b1;
            for (int i = 0; i < N_CORES; i++) begin
                if (haltAt[i] == 0 && h[i]) haltAt[i] = mTotal;
                if (haltAt[i] == 0) everyoneHalted = 1'b0;
            end
            if (everyoneHalted) begin
                mDone = 1'b1;
            end else if (a) begin
                mDone = 1'b1; mAborted = 1'b1;
            end else if (mTotal == MAX_CYCLES) begin
                mDone = 1'b1; mTimeout = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge InputClk) begin
        if (mValid) begin
            checkOutput("core_rst",     64'(runIf.core_rst),     64'({N_CORES{!mRunning()}}));
            checkOutput("running",      64'(runIf.running),      64'(mRunning()));
            checkOutput("done",         64'(runIf.done),         64'(mDone));
            if (mDone) begin
                checkOutput("timeout",  64'(runIf.timeout),      64'(mTimeout));
                checkOutput("aborted",  64'(runIf.aborted),      64'(mAborted));
            end
            checkOutput("halted_mask",  64'(runIf.halted_mask),  64'(mMask()));
            checkOutput("cycles_bus",   64'(runIf.cycles_bus),   64'(mCycles()));
            checkOutput("total_cycles", 64'(runIf.total_cycles), 64'(mTotal));
        end
    end

    task automatic applyStimulus(input logic r, input logic s, input logic a,
                                 input logic [N_CORES-1:0] h);
        rst             = r;
        runIf.start     = s;
        runIf.abort     = a;
        runIf.core_halt = h;
        @(posedge InputClk);
        updateModel(r, s, a, h);
        @(negedge InputClk);
    endtask

    // Start pulse, then the reset hold with start/abort/halts poked to show they are ignored.
    task automatic startRun();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("start clears total", 64'(runIf.total_cycles), 64'd0);
        checkOutput("start clears cycles", 64'(runIf.cycles_bus), 64'd0);
        checkOutput("start clears mask", 64'(runIf.halted_mask), 64'd0);
        checkOutput("start clears flags",
                    64'({runIf.done, runIf.timeout, runIf.aborted}), 64'd0);
        for (int k = 0; k < RESET_CYCLES; k++) begin
            checkOutput("hold core_rst", 64'(runIf.core_rst), 64'h3);
            checkOutput("hold running", 64'(runIf.running), 64'd0);
            applyStimulus(1'b0, k == 1, k == 2, 2'b11);
        end
        checkOutput("run core_rst", 64'(runIf.core_rst), 64'h0);
        checkOutput("run running", 64'(runIf.running), 64'd1);
    endtask

    task automatic runCycles(input int n, input int halt0At, input int halt1At,
                             input int abortAt, input int startAt, input int rstAt);
        for (int k = 1; k <= n; k++)
            applyStimulus(k == rstAt, k == startAt, k == abortAt,
                          {k == halt1At, k == halt0At});
    endtask

    task automatic checkCleanRun();
        checkOutput("s2 cycles_bus", 64'(runIf.cycles_bus), {32'd9, 32'd5});
        checkOutput("s2 halted_mask", 64'(runIf.halted_mask), 64'h3);
        checkOutput("s2 total", 64'(runIf.total_cycles), 64'd9);
        checkOutput("s2 done", 64'(runIf.done), 64'd1);
        checkOutput("s2 timeout", 64'(runIf.timeout), 64'd0);
        checkOutput("s2 core_rst", 64'(runIf.core_rst), 64'h3);
    endtask

    initial begin
        rst = 1'b1; runIf.start = 1'b0; runIf.abort = 1'b0; runIf.core_halt = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11);
        checkOutput("reset core_rst", 64'(runIf.core_rst), 64'h3);
        checkOutput("reset flags",
                    64'({runIf.running, runIf.done, runIf.timeout, runIf.aborted}), 64'd0);

        $display("[TB] clean run, halts on cycles 5 and 9");
        startRun();
        runCycles(9, 5, 9, 0, 0, 0);
        checkCleanRun();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
        checkOutput("done holds total", 64'(runIf.total_cycles), 64'd9);

        $display("[TB] budget timeout with one core halted, start in RUN ignored");
        startRun();
        runCycles(20, 3, 0, 0, 10, 0);
        checkOutput("s3 cycles_bus", 64'(runIf.cycles_bus), {32'd20, 32'd3});
        checkOutput("s3 total", 64'(runIf.total_cycles), 64'd20);
        checkOutput("s3 halted_mask", 64'(runIf.halted_mask), 64'h1);
        checkOutput("s3 timeout", 64'(runIf.timeout), 64'd1);
        checkOutput("s3 aborted", 64'(runIf.aborted), 64'd0);

        $display("[TB] last halts coincide with budget cycle");
        startRun();
        runCycles(20, 20, 20, 0, 0, 0);
        checkOutput("s4 cycles_bus", 64'(runIf.cycles_bus), {32'd20, 32'd20});
        checkOutput("s4 timeout", 64'(runIf.timeout), 64'd0);
        checkOutput("s4 aborted", 64'(runIf.aborted), 64'd0);
        checkOutput("s4 done", 64'(runIf.done), 64'd1);

        $display("[TB] abort on cycle 6");
        startRun();
        runCycles(6, 0, 0, 6, 0, 0);
        checkOutput("abort flag", 64'(runIf.aborted), 64'd1);
        checkOutput("abort timeout", 64'(runIf.timeout), 64'd0);
        checkOutput("abort total", 64'(runIf.total_cycles), 64'd6);
        checkOutput("abort cycles_bus", 64'(runIf.cycles_bus), {32'd6, 32'd6});
        checkOutput("abort mask", 64'(runIf.halted_mask), 64'h0);

        $display("[TB] reset during RUN cycle 7");
        startRun();
        runCycles(7, 2, 0, 0, 0, 7);
        checkOutput("mid-run rst core_rst", 64'(runIf.core_rst), 64'h3);
        checkOutput("mid-run rst counters",
                    64'(runIf.total_cycles) | 64'(runIf.cycles_bus) | 64'(runIf.halted_mask), 64'd0);
        checkOutput("mid-run rst flags",
                    64'({runIf.running, runIf.done, runIf.timeout, runIf.aborted}), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
        checkOutput("idle ignores abort", 64'(runIf.running), 64'd0);
        startRun();
        runCycles(9, 5, 9, 0, 0, 0);
        checkCleanRun();

        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: bench still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
